// File: rtl/modmult_rr_scheduler_if.sv
// rtl/modmult_rr_scheduler_if.sv - requester-side request/response bundle for the shared modular multiplier
interface modmult_rr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 18
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_err;

  // Requesters (lane controllers) drive operands and consume results.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/modmult_rr_scheduler.sv
// rtl/modmult_rr_scheduler.sv - round-robin sharing of one pipelined modular multiplier among NUM_REQ requesters
module modmult_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 18,
  parameter int MODULUS      = 177147,
  parameter int MULT_LATENCY = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  modmult_rr_scheduler_if.slave             rq,
  output logic [DATA_WIDTH-1:0]             mult_a,
  output logic [DATA_WIDTH-1:0]             mult_b,
  input  logic [DATA_WIDTH-1:0]             mult_result,
  output logic                              err_sticky,
  output logic [$clog2(MULT_LATENCY+2)-1:0] in_flight,
  output logic                              idle
);

  localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MULT_LATENCY + 2);
  localparam int LAST  = MULT_LATENCY;
  localparam logic [DATA_WIDTH:0] MOD_V = (DATA_WIDTH+1)'(MODULUS);

  logic [IDW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_id;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  range_err;

  // Tag stage 0 sits alongside the mult_a/mult_b register; the MULT_LATENCY
  // stages after it track the multiplier pipeline, so the last stage is
  // valid exactly when mult_result carries that operation's product.
  logic [LAST:0]         tag_v;
  logic [LAST:0]         tag_e;
  logic [IDW-1:0]        tag_id [LAST+1];

  logic                  ret;

  // Round-robin pick: first valid requester at or above the pointer, with wrap.
  always_comb begin
    int           idx;
    logic [IDW-1:0] sel;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    if (rst_n && enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = IDW'(idx);
        if (!grant_any && rq.req_valid[sel]) begin
          grant[sel] = 1'b1;
          grant_id   = sel;
          grant_any  = 1'b1;
        end
      end
    end
  end

  assign rq.req_ready = grant;

  // Operand mux from the one-hot grant, plus range check of the chosen pair.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        a_sel = rq.req_a[k*DATA_WIDTH +: DATA_WIDTH];
        b_sel = rq.req_b[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    range_err = ({1'b0, a_sel} >= MOD_V) || ({1'b0, b_sel} >= MOD_V);
  end

  // Pointer moves past the winner on every handshake, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Operand register feeding the multiplier; holds when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (grant_any) begin
      mult_a <= a_sel;
      mult_b <= b_sel;
    end
  end

  // Free-running tag pipeline carrying owner id and range flag with each op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_e <= '0;
      for (int k = 0; k <= LAST; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[LAST-1:0], grant_any};
      tag_e     <= {tag_e[LAST-1:0], grant_any & range_err};
      tag_id[0] <= grant_id;
      for (int k = 1; k <= LAST; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  assign ret = tag_v[LAST];

  // Register the product and route it to its owner; error flags latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.resp_valid <= '0;
      rq.resp_data  <= '0;
      rq.resp_err   <= 1'b0;
      err_sticky    <= 1'b0;
    end else if (ret) begin
      rq.resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_id[LAST];
      rq.resp_data  <= mult_result;
      rq.resp_err   <= tag_e[LAST];
      err_sticky    <= err_sticky | tag_e[LAST];
    end else begin
      rq.resp_valid <= '0;
    end
  end

  // Outstanding-operation count: up on issue, down on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({grant_any, ret})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (in_flight == '0) && !grant_any;

endmodule

// File: tb/tb_modmult_rr_scheduler.sv
// tb/tb_modmult_rr_scheduler.sv - scoreboard bench for modmult_rr_scheduler with a behavioural multiplier
module tb_modmult_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int M  = 177147;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] mult_a, mult_b, mult_result;
  logic          err_sticky;
  logic [3:0]    in_flight;
  logic          idle;

  modmult_rr_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) rq ();

  modmult_rr_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MODULUS(M), .MULT_LATENCY(L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rq          (rq),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result),
    .err_sticky  (err_sticky),
    .in_flight   (in_flight),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: L register stages after the operand register.
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= DW'((64'(mult_a) * 64'(mult_b)) % 64'(M));
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mult_result = pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-requester operands and hand-computed expected results.
  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];
  int            op_exp [N];
  bit            op_err [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      rq.req_a[k*DW +: DW] = op_a[k];
      rq.req_b[k*DW +: DW] = op_b[k];
    end
  end

  typedef struct {
    int id;
    int data;
    bit err;
    int t;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int e, input bit er);
    op_a[i]   = DW'(a);
    op_b[i]   = DW'(b);
    op_exp[i] = e;
    op_err[i] = er;
  endtask

  // One cycle of requests, called at a negedge; checks the grant and
  // pushes the expected response for the granted requester.
  task automatic step(input logic [N-1:0] mask, input logic [N-1:0] expg, input string nm);
    exp_t e;
    rq.req_valid = mask;
    #1;
    chk(nm, longint'(rq.req_ready), longint'(expg));
    for (int k = 0; k < N; k++) begin
      if (expg[k]) begin
        e.id   = k;
        e.data = op_exp[k];
        e.err  = op_err[k];
        e.t    = cyc + L + 2;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    rq.req_valid = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0 && in_flight == 0) done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain actual=pending:%0d required=pending:0", nm, q.size());
    end
    chk({nm, "_in_flight"}, longint'(in_flight), 0);
    chk({nm, "_idle"}, longint'(idle), 1);
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rq.resp_valid !== '0) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%b required=none", rq.resp_valid);
      end else begin
        mon_e = q.pop_front();
        chk("resp_valid", longint'(rq.resp_valid), longint'(1 << mon_e.id));
        chk("resp_data", longint'(rq.resp_data), longint'(mon_e.data));
        chk("resp_err", longint'(rq.resp_err), longint'(mon_e.err));
        chk("resp_time", longint'(cyc), longint'(mon_e.t));
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    rq.req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_op(k, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", longint'(rq.req_ready), 0);
    rq.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", longint'(rq.resp_valid), 0);
    chk("rst_resp_data", longint'(rq.resp_data), 0);
    chk("rst_resp_err", longint'(rq.resp_err), 0);
    chk("rst_err_sticky", longint'(err_sticky), 0);
    chk("rst_in_flight", longint'(in_flight), 0);
    chk("rst_idle", longint'(idle), 1);
    chk("rst_mult_a", longint'(mult_a), 0);

    // 1: single op, 2*3
    set_op(0, 2, 3, 6, 1'b0);
    step(4'b0001, 4'b0001, "t1_grant");
    wait_drain("t1");

    // 2: wrap values (pointer now 1)
    set_op(0, 177146, 177146, 1, 1'b0);
    set_op(1, 100000, 2, 22853, 1'b0);
    step(4'b0001, 4'b0001, "t2_grant0");
    step(4'b0010, 4'b0010, "t2_grant1");
    wait_drain("t2");

    // 3: all four valid back to back (pointer 2 -> move it to 0 first)
    set_op(0, 2, 3, 6, 1'b0);
    set_op(2, 1000, 1000, 114265, 1'b0);
    set_op(3, 177146, 2, 177145, 1'b0);
    step(4'b1000, 4'b1000, "t3_align");
    for (int r = 0; r < 12; r++) step(4'b1111, 4'(1 << (r % 4)), "t3_rr_grant");
    chk("t3_in_flight_sat", longint'(in_flight), L + 1);
    wait_drain("t3");

    // 4: fairness, req1 and req3 with pointer at 2
    step(4'b0010, 4'b0010, "t4_align");
    for (int r = 0; r < 8; r++)
      step(4'b1010, (r % 2 == 0) ? 4'b1000 : 4'b0010, "t4_fair_grant");
    wait_drain("t4");

    // 5: out-of-range operand, sticky error (pointer at 2)
    set_op(2, 177147, 5, 0, 1'b1);
    step(4'b0100, 4'b0100, "t5_grant");
    wait_drain("t5");
    chk("t5_err_sticky", longint'(err_sticky), 1);
    step(4'b0001, 4'b0001, "t5_clean_grant");
    wait_drain("t5_clean");
    chk("t5_err_sticky_hold", longint'(err_sticky), 1);

    // 6a: three ops then enable low (pointer at 1)
    set_op(2, 1000, 1000, 114265, 1'b0);
    step(4'b0111, 4'b0010, "t6_grant_a");
    step(4'b0111, 4'b0100, "t6_grant_b");
    step(4'b0111, 4'b0001, "t6_grant_c");
    enable = 1'b0;
    step(4'b0111, 4'b0000, "t6_disabled_grant");
    step(4'b0111, 4'b0000, "t6_disabled_grant");
    chk("t6_busy_not_idle", longint'(idle), 0);
    wait_drain("t6_enable");
    enable = 1'b1;

    // 6b: reset two cycles after issue (pointer 1 before reset)
    step(4'b0001, 4'b0001, "t6_pre_rst_grant");
    step(4'b0000, 4'b0000, "t6_gap");
    rst_n = 1'b0;
    q.delete();
    rq.req_valid = 4'b1111;
    #1;
    chk("t6_rst_req_ready", longint'(rq.req_ready), 0);
    repeat (2) @(negedge clk);
    chk("t6_rst_err_sticky", longint'(err_sticky), 0);
    chk("t6_rst_in_flight", longint'(in_flight), 0);
    rq.req_valid = '0;
    rst_n = 1'b1;
    repeat (L + 4) @(negedge clk);
    step(4'b1111, 4'b0001, "t6_ptr_zero_grant");
    wait_drain("t6_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
